// File: rtl/host_txn_sequencer.sv
// host_txn_sequencer: walks a programmed USB transaction table, offers each entry to the host transactor and
// tallies STALL/timeout/IN-mismatch/NAK-abandon events. Valid throttling enabled by HOST_TXN_SEQUENCER_THROTTLE_EN.
module host_txn_sequencer #(
  parameter int          MAX_PKT   = 8,
  parameter int          DEPTH     = 32,
  parameter int          MAX_RETRY = 3,
  parameter int          THR_LOG2  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int IW = $clog2(DEPTH),
  localparam int NB = $clog2(MAX_PKT) + 1,
  localparam int DW = 8 * MAX_PKT,
  localparam int EW = 15 + NB + DW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_progWr,
  input  logic [IW-1:0] i_progIdx,
  input  logic [EW-1:0] i_progEntry,
  input  logic          i_start,
  input  logic [IW:0]   i_nEntries,
  input  logic          i_txnReady,
  output logic          o_txnValid,
  output logic [2:0]    o_txnType,
  output logic [6:0]    o_txnAddr,
  output logic [3:0]    o_txnEndp,
  output logic [DW-1:0] o_txData,
  output logic [NB-1:0] o_txData_nBytes,
  input  logic          i_rsltValid,
  input  logic [1:0]    i_rsltHs,
  input  logic [DW-1:0] i_rsltData,
  input  logic [NB-1:0] i_rsltData_nBytes,
  output logic          o_busy,
  output logic          o_done,
  output logic [IW-1:0] o_idx,
  output logic [15:0]   o_nStall,
  output logic [15:0]   o_nTimeout,
  output logic [15:0]   o_nMismatch,
  output logic [15:0]   o_nAbandon
);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW:0]     n_q, n_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [15:0]     stall_q, stall_d, tmo_q, tmo_d, mis_q, mis_d, abn_q, abn_d;
  logic [EW-1:0]   tbl_q [DEPTH];
  logic [EW-1:0]   cur;
  logic            cur_chk, issue, txn_valid, last, mis, adv;
  logic [2:0]      cur_type;
  logic [NB-1:0]   cur_nb;
  logic [DW-1:0]   cur_data;

  assign cur      = tbl_q[idx_q];
  assign cur_chk  = cur[EW-1];
  assign cur_type = cur[EW-2 -: 3];
  assign cur_nb   = cur[DW +: NB];
  assign cur_data = cur[DW-1:0];
  assign issue    = (state_q == S_ISSUE);
  assign last     = ({1'b0, idx_q} == (n_q - (IW+1)'(1)));

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Table is plain storage: no reset, writes locked out while a sequence runs.
  always_ff @(posedge i_clk) begin
    if (i_progWr && !o_busy) tbl_q[i_progIdx] <= i_progEntry;
  end

`ifdef HOST_TXN_SEQUENCER_THROTTLE_EN
  logic [15:0] lfsr_q;
  logic        held_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q <= LFSR_SEED;
      held_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      held_q <= txn_valid && !i_txnReady;
    end
  end

  // Throttle only gates the rising edge; once offered, valid holds until accepted.
  assign txn_valid = issue && (held_q || (lfsr_q[THR_LOG2-1:0] == '0));
`else
  assign txn_valid = issue;
`endif

  always_comb begin
    mis = (i_rsltData_nBytes != cur_nb);
    for (int b = 0; b < MAX_PKT; b++) begin
      if ((NB'(b) < cur_nb) && (i_rsltData[8*b +: 8] != cur_data[8*b +: 8])) mis = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    retry_d = retry_q;
    stall_d = stall_q;
    tmo_d   = tmo_q;
    mis_d   = mis_q;
    abn_d   = abn_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          n_d     = i_nEntries;
          idx_d   = '0;
          retry_d = '0;
          stall_d = '0;
          tmo_d   = '0;
          mis_d   = '0;
          abn_d   = '0;
          state_d = (i_nEntries == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (txn_valid && i_txnReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_rsltValid) begin
          adv = 1'b1;
          case (i_rsltHs)
            2'd0: if (cur_chk && (cur_type == 3'b001) && mis) mis_d = sat_inc(mis_q);
            2'd1: begin
              if (retry_q < RW'(MAX_RETRY)) begin
                retry_d = retry_q + RW'(1);
                state_d = S_ISSUE;
                adv     = 1'b0;
              end else begin
                abn_d = sat_inc(abn_q);
              end
            end
            2'd2:    stall_d = sat_inc(stall_q);
            default: tmo_d   = sat_inc(tmo_q);
          endcase
          if (adv) begin
            retry_d = '0;
            if (last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = S_ISSUE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      retry_q <= '0;
      stall_q <= '0;
      tmo_q   <= '0;
      mis_q   <= '0;
      abn_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      retry_q <= retry_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
      mis_q   <= mis_d;
      abn_q   <= abn_d;
    end
  end

  assign o_txnValid      = txn_valid;
  assign o_txnType       = issue ? cur_type : '0;
  assign o_txnAddr       = issue ? cur[EW-5 -: 7] : '0;
  assign o_txnEndp       = issue ? cur[EW-12 -: 4] : '0;
  assign o_txData        = issue ? cur_data : '0;
  assign o_txData_nBytes = issue ? cur_nb : '0;
  assign o_busy          = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign o_done          = (state_q == S_DONE);
  assign o_idx           = idx_q;
  assign o_nStall        = stall_q;
  assign o_nTimeout      = tmo_q;
  assign o_nMismatch     = mis_q;
  assign o_nAbandon      = abn_q;
endmodule

// File: tb/tb_host_txn_sequencer.sv
// Bench for host_txn_sequencer: acts as the host transactor, predicting issue order and counters from a
// per-entry response plan. Define HOST_TXN_SEQUENCER_THROTTLE_EN to check the throttled build.
module tb_host_txn_sequencer;
  localparam int MAX_PKT = 8, DEPTH = 32, MAX_RETRY = 3, THR_LOG2 = 3;
  localparam int IW = $clog2(DEPTH), NB = $clog2(MAX_PKT) + 1, DW = 8 * MAX_PKT, EW = 15 + NB + DW;
  localparam int OW = IW + 3 + 7 + 4 + NB + DW;

  typedef struct packed {
    logic          chk;
    logic [2:0]    typ;
    logic [6:0]    addr;
    logic [3:0]    endp;
    logic [NB-1:0] nb;
    logic [DW-1:0] data;
  } ent_t;

  logic clk, i_rst, i_progWr, i_start, i_txnReady, i_rsltValid;
  logic [IW-1:0] i_progIdx;
  logic [EW-1:0] i_progEntry;
  logic [IW:0] i_nEntries;
  logic [1:0] i_rsltHs;
  logic [DW-1:0] i_rsltData, o_txData;
  logic [NB-1:0] i_rsltData_nBytes, o_txData_nBytes;
  logic o_txnValid, o_busy, o_done;
  logic [2:0] o_txnType;
  logic [6:0] o_txnAddr;
  logic [3:0] o_txnEndp;
  logic [IW-1:0] o_idx;
  logic [15:0] o_nStall, o_nTimeout, o_nMismatch, o_nAbandon;

  host_txn_sequencer #(.MAX_PKT(MAX_PKT), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .THR_LOG2(THR_LOG2),
                       .LFSR_SEED(16'hACE1)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_progWr(i_progWr), .i_progIdx(i_progIdx), .i_progEntry(i_progEntry),
    .i_start(i_start), .i_nEntries(i_nEntries), .i_txnReady(i_txnReady), .o_txnValid(o_txnValid),
    .o_txnType(o_txnType), .o_txnAddr(o_txnAddr), .o_txnEndp(o_txnEndp), .o_txData(o_txData),
    .o_txData_nBytes(o_txData_nBytes), .i_rsltValid(i_rsltValid), .i_rsltHs(i_rsltHs),
    .i_rsltData(i_rsltData), .i_rsltData_nBytes(i_rsltData_nBytes), .o_busy(o_busy), .o_done(o_done),
    .o_idx(o_idx), .o_nStall(o_nStall), .o_nTimeout(o_nTimeout), .o_nMismatch(o_nMismatch),
    .o_nAbandon(o_nAbandon));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  ent_t tbl_m [DEPTH];
  int exp_q[$];
  logic [1:0] rhs_q[$];
  logic [DW-1:0] rdat_q[$];
  logic [NB-1:0] rnb_q[$];
  int e_stall, e_to, e_mm, e_ab;

`ifdef HOST_TXN_SEQUENCER_THROTTLE_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge i_rst)
    if (i_rst) lfsr_m <= 16'hACE1;
    else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] nb_mask(input int nb);
    return (nb >= MAX_PKT) ? {DW{1'b1}} : ((DW'(1) << (8 * nb)) - DW'(1));
  endfunction

  function automatic ent_t mk(input logic chk, input logic [2:0] typ, input logic [6:0] addr,
                              input logic [3:0] endp, input int nb, input logic [DW-1:0] data);
    ent_t e;
    e.chk = chk; e.typ = typ; e.addr = addr; e.endp = endp; e.nb = NB'(nb); e.data = data;
    return e;
  endfunction

  task automatic prog(input int i, input ent_t e);
    @(negedge clk);
    i_progWr = 1'b1; i_progIdx = IW'(i); i_progEntry = e;
    @(negedge clk);
    i_progWr = 1'b0;
    tbl_m[i] = e;
  endtask

  function automatic void plan_clear();
    exp_q.delete(); rhs_q.delete(); rdat_q.delete(); rnb_q.delete();
    e_stall = 0; e_to = 0; e_mm = 0; e_ab = 0;
  endfunction

  function automatic void push(input int e, input logic [1:0] hs, input logic [DW-1:0] d, input int nb);
    exp_q.push_back(e); rhs_q.push_back(hs); rdat_q.push_back(d); rnb_q.push_back(NB'(nb));
  endfunction

  // Entry i is NAKed k times, then answered with fin (unless the NAKs exhaust the retry budget).
  function automatic void plan_entry(input int i, input int k, input logic [1:0] fin,
                                     input logic [DW-1:0] rd, input int rnb);
    ent_t en = tbl_m[i];
    if (k > MAX_RETRY) begin
      for (int j = 0; j <= MAX_RETRY; j++) push(i, 2'd1, rnd64(), 3);
      e_ab++;
    end else begin
      for (int j = 0; j < k; j++) push(i, 2'd1, rnd64(), 3);
      push(i, fin, rd, rnb);
      if (fin == 2'd2) e_stall++;
      if (fin == 2'd3) e_to++;
      if (fin == 2'd0 && en.chk && en.typ == 3'b001 &&
          (rnb != int'(en.nb) || ((rd ^ en.data) & nb_mask(int'(en.nb))) != '0)) e_mm++;
    end
  endfunction

  task automatic run_seq(input int n, input int min_d, input int max_d, input bit rdy_always, input bit disturb);
    int guard, e, d;
    logic [OW-1:0] obs, expv;
    i_txnReady = rdy_always;
    @(negedge clk);
    i_nEntries = (IW+1)'(n); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      guard = 0;
      while (o_txnValid !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      vectors++;
      if (o_txnValid !== 1'b1) begin
        $display("FAIL valid_timeout: issue %0d o_txnValid=%b, required 1", k, o_txnValid);
        miscompares++;
        break;
      end
`ifdef HOST_TXN_SEQUENCER_THROTTLE_EN
      vectors++;
      if (lfsr_m[THR_LOG2-1:0] != '0) begin
        $display("FAIL throttle_rise: issue %0d lfsr low bits=%0h, required 0", k, lfsr_m[THR_LOG2-1:0]);
        miscompares++;
      end
`else
      vectors++;
      if (guard != 0) begin
        $display("FAIL valid_latency: issue %0d valid after %0d cycles, required 0", k, guard);
        miscompares++;
      end
`endif
      expv = {IW'(e), tbl_m[e].typ, tbl_m[e].addr, tbl_m[e].endp, tbl_m[e].nb, tbl_m[e].data};
      obs  = {o_idx, o_txnType, o_txnAddr, o_txnEndp, o_txData_nBytes, o_txData};
      vectors++;
      if (obs !== expv) begin
        $display("FAIL issue_fields: issue %0d got %h, required %h", k, obs, expv);
        miscompares++;
      end
      d = rdy_always ? 0 : $urandom_range(min_d, max_d);
      if (disturb && k == exp_q.size() - 1 && d < 3) d = 3;
      for (int c = 0; c < d; c++) begin
        if (disturb && k == exp_q.size() - 1) begin
          if (c == 0) begin
            i_progWr = 1'b1; i_progIdx = IW'(e); i_progEntry = ~tbl_m[e];
            i_start = 1'b1; i_nEntries = (IW+1)'(n + 1);
          end
          if (c == 1) begin i_rsltValid = 1'b1; i_rsltHs = 2'd2; end
        end
        @(negedge clk);
        i_progWr = 1'b0; i_start = 1'b0; i_rsltValid = 1'b0; i_nEntries = (IW+1)'(n);
        obs = {o_idx, o_txnType, o_txnAddr, o_txnEndp, o_txData_nBytes, o_txData};
        vectors++;
        if (o_txnValid !== 1'b1 || obs !== expv) begin
          $display("FAIL hold_stable: issue %0d cycle %0d valid=%b fields %h, required 1 / %h",
                   k, c, o_txnValid, obs, expv);
          miscompares++;
        end
      end
      if (!rdy_always) i_txnReady = 1'b1;
      @(negedge clk);
      if (!rdy_always) i_txnReady = 1'b0;
      vectors++;
      if (o_txnValid !== 1'b0 || o_busy !== 1'b1) begin
        $display("FAIL accept: issue %0d valid=%b busy=%b, required 0/1", k, o_txnValid, o_busy);
        miscompares++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      i_rsltValid = 1'b1; i_rsltHs = rhs_q[k]; i_rsltData = rdat_q[k]; i_rsltData_nBytes = rnb_q[k];
      @(negedge clk);
      i_rsltValid = 1'b0; i_rsltHs = 2'($urandom); i_rsltData = rnd64();
    end
    i_txnReady = 1'b0;
    vectors++;
    if ({o_done, o_busy} !== 2'b10) begin
      $display("FAIL done: n=%0d done/busy=%b%b, required 10", n, o_done, o_busy);
      miscompares++;
    end
    vectors++;
    if ({o_nStall, o_nTimeout, o_nMismatch, o_nAbandon} !==
        {16'(e_stall), 16'(e_to), 16'(e_mm), 16'(e_ab)}) begin
      $display("FAIL counters: stall/tmo/mis/abn got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               o_nStall, o_nTimeout, o_nMismatch, o_nAbandon, e_stall, e_to, e_mm, e_ab);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({o_txnValid, o_busy, o_done, o_idx} !== '0) begin
      $display("FAIL reset_ctrl: valid/busy/done/idx=%b%b%b/%0d, required all 0", o_txnValid, o_busy, o_done, o_idx);
      miscompares++;
    end
    vectors++;
    if ({o_txnType, o_txnAddr, o_txnEndp, o_txData_nBytes, o_txData} !== '0) begin
      $display("FAIL reset_fields: got %h, required 0", {o_txnType, o_txnAddr, o_txnEndp, o_txData_nBytes, o_txData});
      miscompares++;
    end
    vectors++;
    if ({o_nStall, o_nTimeout, o_nMismatch, o_nAbandon} !== '0) begin
      $display("FAIL reset_counters: got %h, required 0", {o_nStall, o_nTimeout, o_nMismatch, o_nAbandon});
      miscompares++;
    end
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic test_basic();
    plan_clear();
    prog(0, mk(1'b0, 3'b100, 7'd0, 4'd0, 8, rnd64()));
    prog(1, mk(1'b0, 3'b001, 7'd0, 4'd0, 4, rnd64()));
    prog(2, mk(1'b0, 3'b010, 7'd0, 4'd0, 2, rnd64()));
    for (int i = 0; i < 3; i++) plan_entry(i, 0, 2'd0, rnd64(), 8);
    run_seq(3, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_nak_retry();
    plan_clear();
    prog(0, mk(1'b0, 3'b001, 7'd5, 4'd1, 8, rnd64()));
    prog(1, mk(1'b0, 3'b010, 7'd5, 4'd2, 3, rnd64()));
    prog(2, mk(1'b0, 3'b001, 7'd5, 4'd3, 1, rnd64()));
    plan_entry(0, 5, 2'd0, '0, 0);
    plan_entry(1, 0, 2'd0, '0, 0);
    plan_entry(2, MAX_RETRY, 2'd0, rnd64(), 1);
    run_seq(3, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_in_check();
    logic [DW-1:0] x = 64'h0011223344;
    plan_clear();
    prog(0, mk(1'b1, 3'b001, 7'd9, 4'd1, 5, x));
    prog(1, mk(1'b1, 3'b001, 7'd9, 4'd1, 5, x));
    prog(2, mk(1'b1, 3'b001, 7'd9, 4'd1, 5, x));
    prog(3, mk(1'b1, 3'b010, 7'd9, 4'd2, 5, x));
    prog(4, mk(1'b0, 3'b001, 7'd9, 4'd1, 5, x));
    plan_entry(0, 0, 2'd0, 64'h0011223345, 5);
    plan_entry(1, 0, 2'd0, 64'h0011223344, 4);
    plan_entry(2, 0, 2'd0, 64'hDEADBE0011223344, 5);
    plan_entry(3, 0, 2'd0, 64'h0, 0);
    plan_entry(4, 0, 2'd0, 64'h1, 2);
    run_seq(5, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_stall_timeout();
    plan_clear();
    prog(0, mk(1'b0, 3'b010, 7'd3, 4'd4, 1, rnd64()));
    prog(1, mk(1'b0, 3'b001, 7'd3, 4'd5, 2, rnd64()));
    prog(2, mk(1'b0, 3'b100, 7'd3, 4'd0, 8, rnd64()));
    plan_entry(0, 0, 2'd2, '0, 0);
    plan_entry(1, 1, 2'd3, '0, 0);
    plan_entry(2, 0, 2'd0, '0, 0);
    run_seq(3, 0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_entries();
    plan_clear();
    run_seq(0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ready_stall();
    plan_clear();
    prog(0, mk(1'b0, 3'b010, 7'd17, 4'd6, 7, rnd64()));
    prog(1, mk(1'b1, 3'b001, 7'd18, 4'd7, 6, rnd64()));
    plan_entry(0, 0, 2'd0, '0, 0);
    plan_entry(1, 0, 2'd0, tbl_m[1].data, 6);
    run_seq(2, 20, 20, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    int guard = 0;
    plan_clear();
    prog(0, mk(1'b0, 3'b001, 7'd1, 4'd1, 2, rnd64()));
    prog(1, mk(1'b0, 3'b010, 7'd1, 4'd2, 2, rnd64()));
    @(negedge clk);
    i_txnReady = 1'b1; i_nEntries = (IW+1)'(2); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    while (o_txnValid !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    @(negedge clk);
    i_txnReady = 1'b0;
    vectors++;
    if (o_busy !== 1'b1 || o_txnValid !== 1'b0) begin
      $display("FAIL pre_reset_wait: busy/valid=%b%b, required 10", o_busy, o_txnValid);
      miscompares++;
    end
    #2 i_rst = 1'b1;
    #1;
    vectors++;
    if ({o_busy, o_txnValid, o_done} !== 3'b000) begin
      $display("FAIL async_reset: busy/valid/done=%b%b%b, required 000", o_busy, o_txnValid, o_done);
      miscompares++;
    end
    @(negedge clk);
    i_rst = 1'b0;
    prog(0, mk(1'b0, 3'b100, 7'd2, 4'd0, 8, rnd64()));
    prog(1, mk(1'b0, 3'b001, 7'd2, 4'd3, 0, rnd64()));
    plan_entry(0, 0, 2'd0, '0, 0);
    plan_entry(1, 2, 2'd3, '0, 0);
    run_seq(2, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n, k, nb;
    logic [2:0] typ;
    logic [1:0] fin;
    logic [DW-1:0] rd;
    for (int it = 0; it < 6; it++) begin
      plan_clear();
      n = (it == 0) ? DEPTH : $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0: typ = 3'b100;
          1: typ = 3'b010;
          default: typ = 3'b001;
        endcase
        nb = $urandom_range(0, MAX_PKT);
        prog(i, mk(1'($urandom), typ, 7'($urandom), 4'($urandom), nb, rnd64()));
      end
      for (int i = 0; i < n; i++) begin
        k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 5);
        case ($urandom_range(0, 3))
          0: fin = 2'd2;
          1: fin = 2'd3;
          default: fin = 2'd0;
        endcase
        nb = int'(tbl_m[i].nb);
        if ($urandom_range(0, 1) == 0)
          rd = (tbl_m[i].data & nb_mask(nb)) | (rnd64() & ~nb_mask(nb));
        else
          rd = rnd64();
        if ($urandom_range(0, 4) == 0) nb = $urandom_range(0, MAX_PKT);
        plan_entry(i, k, fin, rd, nb);
      end
      run_seq(n, 0, 3, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_progWr = 1'b0; i_progIdx = '0; i_progEntry = '0; i_start = 1'b0;
    i_nEntries = '0; i_txnReady = 1'b0; i_rsltValid = 1'b0; i_rsltHs = '0;
    i_rsltData = '0; i_rsltData_nBytes = '0;
    test_reset();
    test_basic();
    test_nak_retry();
    test_in_check();
    test_stall_timeout();
    test_zero_entries();
    test_ready_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
